// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity constants and baud divider helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud, input int ovs);
    return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator shared by UART rx/tx
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - oversampled UART receiver with error flags and a one-word hold register
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);

  logic                 tick;
  logic                 rx_meta, rx_s;
  uart_state_t          state, state_nx;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           stop_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_acc, par_err_q;
  logic                 stop_err_q, stop_low_q;
  logic                 sample, done, mid_full;

  uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Bits after START are sampled one full bit apart, i.e. at their centres.
  assign mid_full = tick && (scnt == SW'(OVS - 1));

  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: if (!rx_s) state_nx = ST_START;
      ST_START: begin
        if (tick && (scnt == SW'(OVS / 2 - 1))) begin
          sample   = 1'b1;
          state_nx = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (mid_full) begin
          sample = 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1))
            state_nx = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (mid_full) begin
          sample   = 1'b1;
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid_full) begin
          sample = 1'b1;
          if (stop_cnt == 2'(STOP_BITS - 1)) begin
            done     = 1'b1;
            state_nx = ((shift_q == '0) && stop_low_q && !rx_s) ? ST_BRK : ST_IDLE;
          end
        end
      end
      ST_BRK: if (rx_s) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      scnt  <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        scnt <= '0;
      else if (tick)
        scnt <= (scnt == SW'(OVS - 1)) ? '0 : scnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      shift_q    <= '0;
      par_acc    <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      stop_low_q <= 1'b1;
    end else if (sample) begin
      case (state)
        ST_START: begin
          bit_cnt    <= '0;
          stop_cnt   <= '0;
          par_acc    <= 1'b0;
          par_err_q  <= 1'b0;
          stop_err_q <= 1'b0;
          stop_low_q <= 1'b1;
        end
        ST_DATA: begin
          shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
          par_acc <= par_acc ^ rx_s;
          bit_cnt <= bit_cnt + BW'(1);
        end
        ST_PARITY:
          par_err_q <= (PARITY == PARITY_EVEN) ? (par_acc ^ rx_s) : ~(par_acc ^ rx_s);
        ST_STOP: begin
          stop_cnt   <= stop_cnt + 2'd1;
          stop_err_q <= stop_err_q | ~rx_s;
          stop_low_q <= stop_low_q & ~rx_s;
        end
        default: ;
      endcase
    end
  end

  // A completing frame may replace the held word only if it is empty or leaving this clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data    <= shift_q;
        frame_err  <= stop_err_q | ~rx_s;
        parity_err <= (PARITY != PARITY_NONE) && par_err_q;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - scoreboard bench for uart_rx_ovs (8N1 and 8E2 instances)
module tb_uart_rx_ovs;

  localparam int BAUD     = 115200;
  localparam int OVS      = 16;
  localparam int DIV      = 2;
  localparam int CLK_HZ   = DIV * BAUD * OVS;
  localparam int BIT_CLKS = DIV * OVS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic       rx_ready = 1'b1, rx_ready_p = 1'b1;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

  always #5 clk = ~clk;

  uart_rx_ovs #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_ovs #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_p (
    .clk(clk), .reset_n(reset_n), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
    .overrun(overrun_p), .busy(busy_p)
  );

  typedef struct {
    int data;
    int ferr;
    int perr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0, bad = 0;
  int   got0 = 0, got1 = 0, ovr0 = 0, ovr1 = 0;
  bit   ovr0_prev = 1'b0, ovr1_prev = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Frame-level model: word as sent, frame error if any stop bit low, even parity on data+p.
  function automatic exp_t model(input int sel, input int data, input int pbit, input bit stop_ok);
    exp_t e;
    e.data = data;
    e.ferr = stop_ok ? 0 : 1;
    e.perr = (sel == 1) ? ((($countones(data) + pbit) % 2) != 0 ? 1 : 0) : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (rx_valid && rx_ready) begin
        got0++;
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL dut0_unexpected_word: got 0x%0h with no word expected", rx_data);
        end else begin
          e = q0.pop_front();
          chk("dut0_data", int'(rx_data), e.data);
          chk("dut0_frame_err", int'(frame_err), e.ferr);
          chk("dut0_parity_err", int'(parity_err), e.perr);
        end
      end
      if (rx_valid_p && rx_ready_p) begin
        got1++;
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL dut1_unexpected_word: got 0x%0h with no word expected", rx_data_p);
        end else begin
          e = q1.pop_front();
          chk("dut1_data", int'(rx_data_p), e.data);
          chk("dut1_frame_err", int'(frame_err_p), e.ferr);
          chk("dut1_parity_err", int'(parity_err_p), e.perr);
        end
      end
      if (overrun) begin
        ovr0++;
        if (ovr0_prev) chk("dut0_overrun_width", 2, 1);
      end
      if (overrun_p) ovr1++;
      ovr0_prev = overrun;
      ovr1_prev = overrun_p;
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic hold(input int sel, input bit v, input int n);
    if (sel == 0) rx = v; else rx_p = v;
    repeat (n) tick_clk();
  endtask

  // sel 0 drives the 8N1 instance, sel 1 the 8E2 instance.
  task automatic send_frame(input int sel, input int data, input int pbit, input bit stop_ok);
    hold(sel, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(sel, 1'((data >> i) & 1), BIT_CLKS);
    if (sel == 1) hold(sel, 1'(pbit), BIT_CLKS);
    for (int s = 0; s < ((sel == 1) ? 2 : 1); s++) begin
      if (stop_ok) hold(sel, 1'b1, BIT_CLKS);
      else begin
        hold(sel, 1'b0, BIT_CLKS * 3 / 4);
        hold(sel, 1'b1, BIT_CLKS / 4);
      end
    end
  endtask

  task automatic expect_send(input int sel, input int data, input int pbit, input bit stop_ok);
    if (sel == 0) q0.push_back(model(sel, data, pbit, stop_ok));
    else          q1.push_back(model(sel, data, pbit, stop_ok));
    send_frame(sel, data, pbit, stop_ok);
  endtask

  initial begin
    int n, o, d, p;
    bit ok;
    repeat (3) tick_clk();
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_parity_err", int'(parity_err), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_busy_p", int'(busy_p), 0);
    reset_n = 1'b1;
    hold(0, 1'b1, BIT_CLKS);

    expect_send(0, 'hA5, 0, 1'b1);
    hold(0, 1'b1, BIT_CLKS);

    expect_send(1, 'h03, 1, 1'b1);
    hold(1, 1'b1, BIT_CLKS);
    expect_send(1, 'h03, 0, 1'b1);
    hold(1, 1'b1, BIT_CLKS);

    // Start glitch of 4 ticks must be rejected.
    n = got0;
    hold(0, 1'b0, 4 * DIV);
    hold(0, 1'b1, 4);
    chk("glitch_busy_high", int'(busy), 1);
    hold(0, 1'b1, 2 * BIT_CLKS);
    chk("glitch_busy_low", int'(busy), 0);
    chk("glitch_no_word", got0, n);

    rx_ready = 1'b0;
    o = ovr0;
    expect_send(0, 'h11, 0, 1'b1);
    hold(0, 1'b1, BIT_CLKS);
    send_frame(0, 'h22, 0, 1'b1);
    hold(0, 1'b1, BIT_CLKS);
    chk("overrun_pulses", ovr0 - o, 1);
    chk("overrun_valid_held", int'(rx_valid), 1);
    chk("overrun_data_kept", int'(rx_data), 'h11);
    rx_ready = 1'b1;
    hold(0, 1'b1, 4);

    expect_send(0, 'h5A, 0, 1'b0);
    hold(0, 1'b1, BIT_CLKS);
    q0.push_back(model(0, 0, 0, 1'b0));
    hold(0, 1'b0, 20 * BIT_CLKS);
    hold(0, 1'b1, BIT_CLKS);
    expect_send(0, 'h33, 0, 1'b1);
    hold(0, 1'b1, BIT_CLKS);

    // Reset in the middle of a 0xFF frame; the partial word must vanish.
    hold(0, 1'b0, BIT_CLKS);
    hold(0, 1'b1, 4 * BIT_CLKS);
    reset_n = 1'b0;
    repeat (2) tick_clk();
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_valid", int'(rx_valid), 0);
    chk("midreset_data", int'(rx_data), 0);
    reset_n = 1'b1;
    hold(0, 1'b1, BIT_CLKS);
    expect_send(0, 'h0F, 0, 1'b1);
    hold(0, 1'b1, BIT_CLKS);

    expect_send(0, 'h01, 0, 1'b1);
    expect_send(0, 'h02, 0, 1'b1);
    hold(0, 1'b1, BIT_CLKS);

    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d  = int'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      expect_send(0, d, 0, ok);
      hold(0, 1'b1, BIT_CLKS);
    end
    rand_ready = 1'b0;
    rx_ready = 1'b1;

    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(0, 255));
      p = int'($urandom_range(0, 1));
      expect_send(1, d, p, 1'b1);
      hold(1, 1'b1, BIT_CLKS / 2);
    end

    for (int i = 0; i < 2000 && (q0.size() != 0 || q1.size() != 0); i++) tick_clk();
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("total_overrun_dut0", ovr0, 1);
    chk("total_overrun_dut1", ovr1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
